// File: rtl/mode_counter_pkg.sv
// mode_counter_pkg: state enum and direction constants shared by mode_counter
package mode_counter_pkg;
  typedef enum logic {RUN, HALT} cnt_state_t;
  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DOWN = 1'b0;
endpackage

// File: rtl/sticky_flag.sv
// sticky_flag: set/clear flag with set priority and synchronous reset
module sticky_flag (
  input  logic clk,
  input  logic reset,
  input  logic i_set,
  input  logic i_clear,
  output logic o_flag
);
  logic r_flag;
  always_ff @(posedge clk)
    r_flag <= reset ? 1'b0 : i_set ? 1'b1 : i_clear ? 1'b0 : r_flag;
  assign o_flag = r_flag;
endmodule

// File: rtl/mode_counter.sv
// mode_counter: up/down modulo counter with load, one-shot halt and sticky flags.
// Define MODE_COUNTER_SATURATE_EN to make free-run terminal events saturate instead of wrap.
module mode_counter
  import mode_counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MOD_MAX = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             one_shot,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] counter_out,
  output logic             overflow_out,
  output logic             underflow_out,
  output logic             wrap_pulse,
  output logic             done_out
);
`ifdef MODE_COUNTER_SATURATE_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD_MAX);
  cnt_state_t r_state, w_next_state;
  logic [WIDTH-1:0] r_cnt, w_next_cnt, w_ld_val;
  logic r_wrap, w_step, w_term, w_set_ov, w_set_un;
  assign w_ld_val = (load_value > MAX) ? MAX : load_value;
  assign w_step = enable && (r_state == RUN) && !load;
  assign w_term = w_step && ((up_down == CNT_UP) ? (r_cnt == MAX) : (r_cnt == '0));
  assign w_set_ov = w_term && (up_down == CNT_UP);
  assign w_set_un = w_term && (up_down == CNT_DOWN);
  always_comb begin
    w_next_state = r_state;
    w_next_cnt = r_cnt;
    if (load) begin
      w_next_state = RUN;
      w_next_cnt = w_ld_val;
    end else if (w_term) begin
      w_next_state = one_shot ? HALT : RUN;
      // one-shot and saturate both hold the terminal value
      w_next_cnt = (one_shot || SAT) ? r_cnt : (up_down == CNT_UP) ? '0 : MAX;
    end else if (w_step) begin
      w_next_cnt = (up_down == CNT_UP) ? r_cnt + 1'b1 : r_cnt - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_cnt <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt <= w_next_cnt;
      r_wrap <= w_term;
    end
  end
  sticky_flag u_ov (
    .clk(clk), .reset(reset), .i_set(w_set_ov), .i_clear(clear_flags), .o_flag(overflow_out)
  );
  sticky_flag u_un (
    .clk(clk), .reset(reset), .i_set(w_set_un), .i_clear(clear_flags), .o_flag(underflow_out)
  );
  assign counter_out = r_cnt;
  assign wrap_pulse = r_wrap;
  assign done_out = (r_state == HALT);
endmodule

// File: tb/tb_mode_counter.sv
// tb_mode_counter: scoreboard bench driving two counters (mod 16 and mod 10) with shared stimulus
module tb_mode_counter;
`ifdef MODE_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef struct {int cnt; bit ov; bit un; bit wp; bit halt;} mdl_t;
  typedef struct {logic [8:0] a; logic [8:0] b;} exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b0, up_down = 1'b1, one_shot = 1'b0, load = 1'b0, clear_flags = 1'b0;
  logic [4:0] load_value = '0;
  logic [3:0] a_cnt;
  logic [4:0] b_cnt;
  logic a_ov, a_un, a_wp, a_done, b_ov, b_un, b_wp, b_done;
  exp_t q[$];
  mdl_t ma, mb;
  int n_cmp = 0, n_bad = 0, cyc = 0;

  always #5 clk = ~clk;

  mode_counter #(.WIDTH(4), .MOD_MAX(15)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .one_shot(one_shot),
    .load(load), .load_value(load_value[3:0]), .clear_flags(clear_flags),
    .counter_out(a_cnt), .overflow_out(a_ov), .underflow_out(a_un),
    .wrap_pulse(a_wp), .done_out(a_done)
  );
  mode_counter #(.WIDTH(5), .MOD_MAX(9)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .one_shot(one_shot),
    .load(load), .load_value(load_value), .clear_flags(clear_flags),
    .counter_out(b_cnt), .overflow_out(b_ov), .underflow_out(b_un),
    .wrap_pulse(b_wp), .done_out(b_done)
  );

  function automatic mdl_t step(mdl_t s, int mx, bit rst, bit ld, int lv, bit en, bit ud, bit os, bit clr);
    mdl_t n = s;
    bit term;
    n.wp = 1'b0;
    if (rst) begin
      n = '{0, 1'b0, 1'b0, 1'b0, 1'b0};
      return n;
    end
    term = !ld && en && !s.halt && (ud ? s.cnt == mx : s.cnt == 0);
    if (ld) begin
      n.cnt = (lv > mx) ? mx : lv;
      n.halt = 1'b0;
    end else if (term) begin
      n.wp = 1'b1;
      if (os) n.halt = 1'b1;
      else if (!SAT) n.cnt = ud ? 0 : mx;
    end else if (en && !s.halt) begin
      n.cnt = ud ? s.cnt + 1 : s.cnt - 1;
    end
    n.ov = (term && ud) ? 1'b1 : clr ? 1'b0 : s.ov;
    n.un = (term && !ud) ? 1'b1 : clr ? 1'b0 : s.un;
    return n;
  endfunction

  function automatic logic [8:0] pk(mdl_t s);
    return {5'(s.cnt), s.ov, s.un, s.wp, s.halt};
  endfunction

  task automatic drive(bit rst, bit ld, logic [4:0] lv, bit en, bit ud, bit os, bit clr);
    exp_t e;
    @(negedge clk);
    reset = rst; load = ld; load_value = lv; enable = en;
    up_down = ud; one_shot = os; clear_flags = clr;
    ma = step(ma, 15, rst, ld, int'(lv[3:0]), en, ud, os, clr);
    mb = step(mb, 9, rst, ld, int'(lv), en, ud, os, clr);
    e.a = pk(ma);
    e.b = pk(mb);
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    if (q.size() > 0) begin
      exp_t e;
      logic [8:0] ga, gb;
      e = q.pop_front();
      ga = {1'b0, a_cnt, a_ov, a_un, a_wp, a_done};
      gb = {b_cnt, b_ov, b_un, b_wp, b_done};
      n_cmp++;
      if (ga !== e.a || gb !== e.b) begin
        n_bad++;
        $display("FAIL cycle%0d {cnt,ov,un,wrap,done}: got a=%h b=%h want a=%h b=%h",
                 cyc, ga, gb, e.a, e.b);
      end
    end
  end

  initial begin
    ma = '{0, 1'b0, 1'b0, 1'b0, 1'b0};
    mb = ma;
    repeat (2) drive(1, 0, 0, 0, 1, 0, 0);
    repeat (17) drive(0, 0, 0, 1, 1, 0, 0);
    drive(0, 1, 5'd2, 0, 0, 0, 0);
    repeat (4) drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 1, 5'd13, 0, 1, 1, 0);
    repeat (5) drive(0, 0, 0, 1, 1, 1, 0);
    drive(0, 1, 5'd3, 1, 1, 1, 0);
    drive(0, 0, 0, 0, 1, 0, 1);
    drive(0, 1, 5'd15, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 1, 0, 1);
    drive(0, 1, 5'd7, 1, 1, 0, 0);
    drive(0, 1, 5'd20, 1, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 1, 1, 0, 0);
    drive(0, 1, 5'd15, 0, 1, 1, 0);
    repeat (2) drive(0, 0, 0, 1, 1, 1, 0);
    drive(1, 0, 0, 1, 1, 1, 0);
    repeat (5) drive(0, 0, 0, 1, 1, 0, 0);
    drive(1, 0, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      int r0 = $urandom_range(0, 99);
      int r1 = $urandom_range(0, 99);
      drive(r0 < 2, r1 < 8, 5'($urandom_range(0, 31)), $urandom_range(0, 99) < 80,
            $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 10);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected responses left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mode_counter.md
# mode_counter

Parametrised up/down counter with load, a configurable terminal value, free-run or one-shot operation, and sticky overflow/underflow flags. It generalises the team's 4-bit enable counter and serves as the general-purpose event and timeout counter for control blocks. All outputs are registered in the `clk` domain.

## Interface
- `WIDTH`, 8: counter width in bits; minimum 2.
- `MOD_MAX`, `2**WIDTH-1`: terminal value; the count range is 0..`MOD_MAX`; must be at least 1.
- `clk` input, 1 bit: rising-edge clock, the only clock.
- `reset` input, 1 bit: synchronous, active-high reset.
- `enable` input, 1 bit: advances the count by one step per cycle while high.
- `up_down` input, 1 bit: 1 counts up, 0 counts down; sampled every cycle.
- `one_shot` input, 1 bit: 1 selects one-shot mode, 0 selects free-run; sampled every cycle.
- `load` input, 1 bit: synchronous load of `load_value`.
- `load_value` input, `WIDTH` bits: load data; values above `MOD_MAX` are clamped to `MOD_MAX`.
- `clear_flags` input, 1 bit: clears both sticky flags.
- `counter_out` output, `WIDTH` bits: current count.
- `overflow_out` output, 1 bit: sticky; set by an up-wrap at `MOD_MAX`.
- `underflow_out` output, 1 bit: sticky; set by a down-wrap at 0.
- `wrap_pulse` output, 1 bit: single-cycle pulse on every wrap event.
- `done_out` output, 1 bit: high while the block is in the HALT state.

## Operation
- Priority: `reset` > `load` > counting.
- State machine, two states: RUN and HALT.
  - Reset enters RUN.
  - `load` always enters RUN.
  - RUN goes to HALT on a terminal event while `one_shot`=1.
  - HALT stays in HALT until `load` or `reset`; `enable` is ignored in HALT.
- Terminal event: `enable`=1 in RUN and either
  - `up_down`=1 and count = `MOD_MAX`, or
  - `up_down`=0 and count = 0.
- Free-run terminal event:
  - Up: count becomes 0 and `overflow_out` is set.
  - Down: count becomes `MOD_MAX` and `underflow_out` is set.
  - `wrap_pulse`=1 in both cases.
- One-shot terminal event:
  - The count holds at its terminal value and the state goes to HALT.
  - The flag for that direction is set and `wrap_pulse`=1.
- Non-terminal cycles: count ±1 when `enable`=1, otherwise hold. No flags change.
- `clear_flags` and a flag-setting event in the same cycle: the set wins.
- `load` and `enable` in the same cycle: the load wins and no count step occurs. `load` does not touch the flags.
- Arithmetic is modulo `MOD_MAX`+1, never the natural 2^`WIDTH` wrap, unless the two are equal.

## Timing
- Reset values: `counter_out`=0, `overflow_out`=0, `underflow_out`=0, `wrap_pulse`=0, `done_out`=0, state RUN.
- All outputs are registered. Every effect appears at the edge that samples the cause; latency is 1 cycle.
- `wrap_pulse` is high for exactly one cycle, coincident with the post-wrap count.
- `done_out` rises in the same cycle that HALT is entered and falls the cycle after `load`.
- Reset in any state, including mid-count or HALT, takes effect at the next edge.

## Configuration
- `MODE_COUNTER_SATURATE_EN` defined:
  - Free-run terminal events saturate instead of wrapping. The count holds at `MOD_MAX` (up) or 0 (down).
  - The flag is still set and `wrap_pulse` still fires, on each terminal cycle.
  - The state remains RUN.
- `MODE_COUNTER_SATURATE_EN` undefined: free-run wraps as described in Operation.
- One-shot behaviour is identical in both builds.

## Structure
- Package `mode_counter_pkg` holds:
  - the state enum `cnt_state_t` (RUN, HALT);
  - direction constants `CNT_UP`=1 and `CNT_DOWN`=0.
- Sub-module `sticky_flag`:
  - Instanced twice, once for overflow and once for underflow.
  - Inputs are set and clear with set priority; it has a synchronous reset.
- The counter datapath and state machine live in `mode_counter`.

## Test plan
- Reset sequencing: hold `reset` for 2 cycles, then hold `enable`=1 with free-run up, `WIDTH`=4, `MOD_MAX`=15. Outputs are 0 after reset; the count reaches 15 after 15 cycles, then reads 0 with `wrap_pulse`=1 and `overflow_out`=1.
- Non-power-of-two modulus: `MOD_MAX`=9, down from a load of 2. Count sequence 2,1,0,9; `underflow_out`=1 at 9.
- One-shot up: `load_value`=13 with `MOD_MAX`=15, `one_shot`=1. Counts 14,15, then holds at 15 with `done_out`=1; further `enable` has no effect. A later `load` of 3 gives count 3 and `done_out` falls.
- Simultaneous events:
  - `clear_flags` in the same cycle as an overflow event leaves `overflow_out`=1.
  - `load` together with `enable` yields exactly `load_value`.
  - `load_value`=20 with `MOD_MAX`=15 loads 15.
- Reset in HALT and mid-count: all outputs return to 0 the next cycle and the state is RUN.
- `MODE_COUNTER_SATURATE_EN` build: free-run up at 15 holds at 15 while `enable` stays high. `wrap_pulse` is high every cycle at 15 and `overflow_out`=1.
